// File: rtl/cpu_run_mon_pkg.sv
// Shared types and sizing helpers for the CPU run monitor.
// Optional r0 write-back filter: CPU_RUN_MON_R0_FILTER_EN.
package cpu_run_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

  localparam int TR_ADDR_W = 5;
  localparam int TR_DATA_W = 32;
  localparam int TR_CNT_W  = 16;

  typedef struct packed {
    logic [TR_ADDR_W-1:0] addr;
    logic [TR_DATA_W-1:0] data;
    logic [TR_CNT_W-1:0]  cycle;
  } trace_entry_t;

  localparam int TRACE_DEPTH_DEF = 16;
  localparam int TRACE_PTR_W = $clog2(TRACE_DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO for write-back trace entries.
// Head entry is presented combinationally; zero when empty.
module trace_fifo
  import cpu_run_mon_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = TRACE_DEPTH_DEF,
  parameter int PTR_W = TRACE_PTR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  assign count_o = count;
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the slot the simultaneous push lands in.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !clr_i) begin
      mem[wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Bounded run controller with register write-back trace capture.
// Define CPU_RUN_MON_R0_FILTER_EN to drop write-backs to r0.
module cpu_run_monitor
  import cpu_run_mon_pkg::*;
#(
  parameter int END_COUNT   = 5,
  parameter int DATA_W      = TR_DATA_W,
  parameter int ADDR_W      = TR_ADDR_W,
  parameter int CNT_W       = TR_CNT_W,
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              trace_rd_i,
  output logic              running_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              trace_valid_o,
  output logic [ADDR_W-1:0] trace_addr_o,
  output logic [DATA_W-1:0] trace_data_o,
  output logic [CNT_W-1:0]  trace_cycle_o,
  output logic              overflow_o
);

  localparam int PTR_W = ptr_w(TRACE_DEPTH);
  localparam int EW    = ADDR_W + DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(END_COUNT - 1);

  run_state_e       state;
  run_state_e       state_nx;
  logic             start_run;
  logic [CNT_W-1:0] cnt;
  logic             push_q;
  logic             drop;
  logic             ovf;
  logic             f_full;
  logic             f_empty;
  logic [PTR_W:0]   f_count;
  logic [EW-1:0]    f_dout;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_run = 1'b0;
    unique case (1'b1)
      (state == ST_RUN): begin
        if (cnt == LAST) state_nx = ST_DONE;
      end
      (state == ST_IDLE),
      (state == ST_DONE): begin
        if (start_i) begin
          state_nx  = ST_RUN;
          start_run = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_run) cnt <= '0;
    else if (state == ST_RUN) cnt <= cnt + 1'b1;
  end

`ifdef CPU_RUN_MON_R0_FILTER_EN
  assign push_q = (state == ST_RUN) && wb_en_i
                  && (wb_addr_i != '0);
`else
  assign push_q = (state == ST_RUN) && wb_en_i;
`endif

  assign drop = push_q && f_full
                && !(trace_rd_i && (f_count != '0));

  always_ff @(posedge clk_i) begin
    if (rst_i || start_run) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

  trace_fifo #(
    .W     (EW),
    .DEPTH (TRACE_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_run),
    .push_i  (push_q),
    .pop_i   (trace_rd_i),
    .din_i   ({wb_addr_i, wb_data_i, cnt}),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  assign running_o     = (state == ST_RUN);
  assign done_o        = (state == ST_DONE);
  assign cycle_cnt_o   = cnt;
  assign trace_valid_o = !f_empty;
  assign overflow_o    = ovf;
  assign {trace_addr_o, trace_data_o, trace_cycle_o} = f_dout;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: directed scenarios then random traffic.
// A queue-based reference model predicts every cycle's outputs.
module tb_cpu_run_monitor;

  localparam int EC = 8;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rd;
  logic          running;
  logic          done;
  logic [CW-1:0] cnt;
  logic          tvalid;
  logic [AW-1:0] taddr;
  logic [DW-1:0] tdata;
  logic [CW-1:0] tcyc;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .END_COUNT   (EC),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .CNT_W       (CW),
    .TRACE_DEPTH (TD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .wb_en_i       (wb_en),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .trace_rd_i    (rd),
    .running_o     (running),
    .done_o        (done),
    .cycle_cnt_o   (cnt),
    .trace_valid_o (tvalid),
    .trace_addr_o  (taddr),
    .trace_data_o  (tdata),
    .trace_cycle_o (tcyc),
    .overflow_o    (ovf)
  );

  typedef struct {
    logic          run;
    logic          done;
    logic [CW-1:0] cnt;
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cyc;
    logic          ovf;
  } snap_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  snap_t exp_q[$];
  ent_t  m_q[$];
  bit    m_run;
  bit    m_done;
  bit    m_ovf;
  int    m_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue and a run counter.
  always @(posedge clk) begin
    snap_t s;
    ent_t  e;
    bit    pop;
    bit    cap;
    if (rst) begin
      m_run = 0; m_done = 0; m_cnt = 0; m_ovf = 0;
      m_q.delete();
    end else if (!m_run && start) begin
      m_run = 1; m_done = 0; m_cnt = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      pop = rd && (m_q.size() > 0);
      cap = m_run && wb_en;
`ifdef CPU_RUN_MON_R0_FILTER_EN
      cap = cap && (wb_addr != 0);
`endif
      e.a = wb_addr;
      e.d = wb_data;
      e.c = CW'(m_cnt);
      if (m_run) begin
        m_cnt++;
        if (m_cnt == EC) begin
          m_run = 0;
          m_done = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < TD) m_q.push_back(e);
        else m_ovf = 1;
      end
    end
    s.run   = m_run;
    s.done  = m_done;
    s.cnt   = CW'(m_cnt);
    s.ovf   = m_ovf;
    s.valid = (m_q.size() > 0);
    s.addr  = s.valid ? m_q[0].a : '0;
    s.data  = s.valid ? m_q[0].d : '0;
    s.cyc   = s.valid ? m_q[0].c : '0;
    exp_q.push_back(s);
  end

  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("running", running, s.run);
      chk("done", done, s.done);
      chk("cycle_cnt", cnt, s.cnt);
      chk("trace_valid", tvalid, s.valid);
      chk("trace_addr", taddr, s.addr);
      chk("trace_data", tdata, s.data);
      chk("trace_cycle", tcyc, s.cyc);
      chk("overflow", ovf, s.ovf);
    end
  end

  task automatic step(input logic r, input logic s,
                      input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic p);
    rst = r; start = s; wb_en = we;
    wb_addr = a; wb_data = d; rd = p;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    int ea[3];
    int ed[3];
    int es[3];
    ea = '{1, 2, 3};
    ed = '{10, 20, 30};
    es = '{0, 2, 4};

    step(1, 0, 0, '0, '0, 0);
    step(1, 1, 0, '0, '0, 0);
    chk("rst_running", running, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_valid", tvalid, 0);
    step(0, 0, 1, 5'd4, 32'h44, 0);
    chk("idle_no_capture", tvalid, 0);

    // Plain run, no write-backs.
    step(0, 1, 0, '0, '0, 0);
    for (int k = 0; k < EC; k++) begin
      chk("run_window", running, 1);
      step(0, 0, 0, '0, '0, 0);
    end
    chk("done_after_run", done, 1);
    chk("done_cnt", cnt, EC);
    chk("done_empty", tvalid, 0);

    // Sparse write-backs, drained after DONE.
    step(0, 1, 0, '0, '0, 0);
    for (int k = 0; k < EC; k++) begin
      if (k == 0) step(0, 0, 1, 5'd1, 32'd10, 0);
      else if (k == 2) step(0, 0, 1, 5'd2, 32'd20, 0);
      else if (k == 4) step(0, 0, 1, 5'd3, 32'd30, 0);
      else step(0, 0, 0, '0, '0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("pop_addr", taddr, ea[i]);
      chk("pop_data", tdata, ed[i]);
      chk("pop_stamp", tcyc, es[i]);
      step(0, 0, 0, '0, '0, 1);
    end
    chk("drained", tvalid, 0);
    step(0, 0, 0, '0, '0, 1);
    chk("pop_empty_ignored", tvalid, 0);

    // Overflow: write every cycle, no pops.
    step(0, 1, 0, '0, '0, 0);
    for (int k = 0; k < EC; k++)
      step(0, 0, 1, AW'(k + 1), $urandom, 0);
    chk("ovf_set", ovf, 1);
    for (int i = 0; i < TD; i++) begin
      chk("ovf_stamp", tcyc, i);
      step(0, 0, 0, '0, '0, 1);
    end
    chk("ovf_sticky", ovf, 1);

    // Full with simultaneous push and pop.
    step(0, 1, 0, '0, '0, 0);
    for (int k = 0; k < EC; k++)
      step(0, 0, 1, AW'(k + 1), $urandom, k >= TD);
    chk("nodrop_ovf", ovf, 0);
    chk("nodrop_head", tcyc, EC - TD);

    // Reset wins over start mid-run.
    step(0, 1, 0, '0, '0, 0);
    step(0, 0, 1, 5'd6, 32'h66, 0);
    step(0, 0, 1, 5'd7, 32'h77, 0);
    step(1, 1, 1, 5'd8, 32'h88, 0);
    chk("rst_mid_running", running, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_cnt", cnt, 0);
    chk("rst_mid_valid", tvalid, 0);
    chk("rst_mid_ovf", ovf, 0);

    // r0 write-back.
    step(0, 1, 0, '0, '0, 0);
    step(0, 0, 1, 5'd0, 32'd7, 0);
    idle(EC - 1);
`ifdef CPU_RUN_MON_R0_FILTER_EN
    chk("r0_filtered", tvalid, 0);
`else
    chk("r0_kept", tvalid, 1);
    chk("r0_data", tdata, 7);
`endif

    // Restart from DONE with unread entries.
    step(0, 1, 0, '0, '0, 0);
    step(0, 0, 1, 5'd9, 32'h99, 0);
    step(0, 0, 1, 5'd10, 32'haa, 0);
    idle(EC - 2);
    chk("pre_restart_valid", tvalid, 1);
    step(0, 1, 0, '0, '0, 0);
    chk("restart_cnt", cnt, 0);
    chk("restart_valid", tvalid, 0);
    chk("restart_ovf", ovf, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1,
           a, $urandom,
           $urandom_range(0, 2) == 0);
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
